// File: rtl/riscv_soft_host_mem_master.sv
// Burst master for the unified-memory host port: takes one load/store command,
// issues cmd_len+1 word requests at consecutive addresses, and waits for the
// matching in-order responses before signalling completion.
module riscv_soft_host_mem_master #(
  parameter int unsigned XPR_LEN      = 32,
  parameter int unsigned LEN_W        = 8,
  parameter logic [2:0]  OP_TYPE_WORD = 3'd2
) (
  input  logic               clk,
  input  logic               reset,
  // command
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [XPR_LEN-1:0] cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  // store-data stream
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [XPR_LEN-1:0] wr_data,
  // host request
  input  logic               host_req_ready,
  output logic               host_req_valid,
  output logic [1:0]         host_req_op,
  output logic [2:0]         host_req_op_type,
  output logic [XPR_LEN-1:0] host_req_addr,
  output logic [XPR_LEN-1:0] host_req_data,
  // host response
  input  logic               host_resp_valid,
  input  logic [XPR_LEN-1:0] host_resp_data,
  // load data
  output logic               rd_valid,
  output logic [XPR_LEN-1:0] rd_data,
  // status
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [1:0] MemLoad  = 2'd0;
  localparam logic [1:0] MemStore = 2'd1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e             state_q, state_d;
  logic [XPR_LEN-1:0] addr_q, addr_d;
  logic [LEN_W:0]     beats_q, beats_d;
  logic [LEN_W:0]     issued_q, issued_d;
  logic [LEN_W:0]     resp_q, resp_d;
  logic               write_q, write_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic cmd_fire;
  logic req_fire;
  logic resp_ok;
  logic resp_bad;

  // Handshakes and combinational port drive derived from the current state.
  always_comb begin
    // cmd_ready stays low while reset is held, even though the state is already idle
    cmd_ready        = reset & (state_q == StIdle);
    host_req_valid   = (state_q == StIssue) & (write_q ? wr_valid : 1'b1);
    host_req_op      = write_q ? MemStore : MemLoad;
    host_req_op_type = OP_TYPE_WORD;
    host_req_addr    = addr_q;
    host_req_data    = wr_data;
    wr_ready         = (state_q == StIssue) & write_q & host_req_ready;
    cmd_fire         = cmd_valid & cmd_ready;
    req_fire         = host_req_valid & host_req_ready;
    // A response only counts while a burst still owes one; anything else is a protocol error
    resp_ok          = host_resp_valid & (state_q != StIdle) & (resp_q != beats_q);
    resp_bad         = host_resp_valid & ~resp_ok;
    rd_valid         = resp_ok & ~write_q;
    rd_data          = host_resp_data;
    busy             = (state_q != StIdle);
    done             = done_q;
    err              = err_q;
  end

  // Next-state logic for the burst sequencer and its counters.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    issued_d = issued_q;
    resp_d   = resp_q + {{LEN_W{1'b0}}, resp_ok};
    write_d  = write_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          state_d  = StIssue;
          addr_d   = cmd_addr;
          beats_d  = {1'b0, cmd_len} + {{LEN_W{1'b0}}, 1'b1};
          issued_d = '0;
          resp_d   = '0;
          write_d  = cmd_write;
          err_d    = 1'b0;
        end
      end
      StIssue: begin
        if (req_fire) begin
          addr_d   = addr_q + {{(XPR_LEN-1){1'b0}}, 1'b1};
          issued_d = issued_q + {{LEN_W{1'b0}}, 1'b1};
          if (issued_d == beats_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (resp_d == beats_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Error set wins over the clear on command acceptance
    if (resp_bad) begin
      err_d = 1'b1;
    end
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      beats_q  <= '0;
      issued_q <= '0;
      resp_q   <= '0;
      write_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      issued_q <= issued_d;
      resp_q   <= resp_d;
      write_q  <= write_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/riscv_soft_host_mem_master.md
RISCV_SOFT_HOST_MEM_MASTER -- requirements
Module: riscv_soft_host_mem_master

Interface
REQ-001 Parameter XPR_LEN, default 32: address/data width.
REQ-002 Parameter LEN_W, default 8: burst length field width.
REQ-003 Parameter OP_TYPE_WORD, default 3'd2: constant driven on host_req_op_type.
REQ-004 Port clk  in  1  sole clock; all logic is rising-edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Ports cmd_valid in 1, cmd_ready out 1: command handshake; accepted when both are high on a clk edge.
REQ-007 Ports cmd_write in 1, cmd_addr in XPR_LEN, cmd_len in LEN_W: store/load select, word start address, beats minus one.
REQ-008 Ports wr_valid in 1, wr_ready out 1, wr_data in XPR_LEN: store-data stream, one word per beat.
REQ-009 Ports host_req_ready in 1, host_req_valid out 1, host_req_op out 2, host_req_op_type out 3, host_req_addr out XPR_LEN, host_req_data out XPR_LEN: host request port toward the unified memory.
REQ-010 Ports host_resp_valid in 1, host_resp_data in XPR_LEN: host response port.
REQ-011 Ports rd_valid out 1, rd_data out XPR_LEN: load data output, no backpressure.
REQ-012 Ports busy out 1, done out 1, err out 1: burst in progress, one-cycle completion pulse, sticky protocol error.

Function
REQ-013 States SHALL be IDLE, ISSUE, DRAIN.
REQ-014 cmd_ready SHALL be 1 only in IDLE.
REQ-015 IDLE->ISSUE on command acceptance; command fields, address and beat count (cmd_len+1, range 1..2^LEN_W) are latched; err is cleared.
REQ-016 In ISSUE, a beat SHALL be issued on a cycle where host_req_valid and host_req_ready are both high.
REQ-017 Loads: host_req_valid = 1 in ISSUE; host_req_op = `MEM_LOAD.
REQ-018 Stores: host_req_valid = wr_valid in ISSUE; host_req_op = `MEM_STORE; host_req_data = wr_data; wr_ready = host_req_ready in ISSUE for stores, else 0.
REQ-019 host_req_valid SHALL be 0 outside ISSUE; host_req_op_type SHALL always equal OP_TYPE_WORD.
REQ-020 host_req_addr SHALL start at cmd_addr and increment by 1 per issued beat, wrapping modulo 2^XPR_LEN.
REQ-021 Once asserted, host_req_valid with addr/op/data SHALL be held stable until issued.
REQ-022 ISSUE->DRAIN on the cycle the last beat is issued; back-to-back beats allowed, one per cycle.
REQ-023 Responses are in order, one per issued beat, arriving one or more cycles after issue; a response counter (LEN_W+1 bits) SHALL count host_resp_valid cycles in ISSUE and DRAIN.
REQ-024 For loads, each response cycle SHALL assert rd_valid with rd_data = host_resp_data in the same cycle (combinational pass-through); rd_valid = 0 for stores.
REQ-025 DRAIN->IDLE on the cycle the response count reaches the beat count; done is asserted for exactly that one cycle (registered, visible the following cycle).
REQ-026 A response arriving and the final beat issuing in the same cycle SHALL both be counted.
REQ-027 host_resp_valid while IDLE, or when the response count already equals the beat count, SHALL set err and otherwise be ignored.
REQ-028 busy = 1 in ISSUE and DRAIN.

Reset
REQ-029 Reset low SHALL immediately force IDLE and clear counters, latched command, err and done.
REQ-030 During reset: host_req_valid, wr_ready, rd_valid, busy and done = 0; cmd_ready = 1 only after reset deasserts.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; no done is produced for it.

Verification
REQ-032 Load, cmd_addr=0x10, cmd_len=3, host_req_ready=1, responses 1 cycle later -> addrs 0x10..0x13 on consecutive cycles, four rd_valid pulses carrying the response data, one done, busy for 5 cycles.
REQ-033 Store, cmd_len=1, wr_data 0xDEADBEEF then 0x12345678, wr_valid gapped by 2 cycles -> host_req_valid only with wr_valid, stores to addr and addr+1 with those data, done after second response.
REQ-034 host_req_ready low 3 cycles mid-burst -> host_req_valid/addr/op held stable, no beat skipped or duplicated.
REQ-035 cmd_addr=0xFFFFFFFF, cmd_len=1 load -> second beat addr 0x00000000.
REQ-036 host_resp_valid pulsed in IDLE -> err=1, no rd_valid; next accepted command clears err.
REQ-037 Reset asserted after 2 of 4 load beats -> outputs cleared asynchronously, no done; new command after release completes normally.
